// File: rtl/axi_stream_pkg.sv
// Shared constants and helpers for the AXI4-Stream checker.
package axi_stream_pkg;

  localparam int unsigned VIOL_VALID_DROP        = 0;
  localparam int unsigned VIOL_PAYLOAD_CHANGE    = 1;
  localparam int unsigned VIOL_STRB_NOT_KEEP     = 2;
  localparam int unsigned VIOL_VALID_AFTER_RESET = 3;
  localparam int unsigned VIOL_PACKET_TOO_LONG   = 4;
  localparam int unsigned VIOL_INTERLEAVE        = 5;
  localparam int unsigned VIOL_STALL_TIMEOUT     = 6;
  localparam int unsigned VIOL_COUNT             = 7;

  // Add inc to a w-bit counter value, clamping at all-ones (w <= 63).
  function automatic logic [63:0] sat_inc(input logic [63:0] a, input logic [63:0] inc,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [64:0] sum;
    max_v = {64{1'b1}} >> (64 - w);
    sum   = {1'b0, a} + {1'b0, inc};
    if (sum > {1'b0, max_v}) begin
      sat_inc = max_v;
    end else begin
      sat_inc = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/axi_stream_popcount.sv
// Combinational population count of a byte-qualifier vector.
module axi_stream_popcount #(
  parameter int unsigned width     = 4,
  parameter int unsigned out_width = $clog2(width + 1)
) (
  input  logic [width-1:0]     bits_i,
  output logic [out_width-1:0] count_o
);

  // Sum the set bits.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(width); i++) begin
      count_o = count_o + out_width'(bits_i[i]);
    end
  end

endmodule

// File: rtl/axi_stream_checker.sv
// Passive AXI4-Stream protocol checker with saturating traffic statistics.
module axi_stream_checker
  import axi_stream_pkg::*;
#(
  parameter int unsigned byte_width       = 4,
  parameter int unsigned id_width         = 0,
  parameter int unsigned dest_width       = 0,
  parameter int unsigned user_width       = 0,
  parameter int unsigned count_width      = 32,
  parameter int unsigned max_packet_len   = 0,
  parameter int unsigned stall_limit      = 0,
  parameter bit          allow_interleave = 1'b1
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  input  logic                                           clear,
  input  logic                                           tvalid,
  input  logic                                           tready,
  input  logic                                           tlast,
  input  logic [8*byte_width-1:0]                        tdata,
  input  logic [byte_width-1:0]                          tstrb,
  input  logic [byte_width-1:0]                          tkeep,
  input  logic [(id_width > 0 ? id_width : 1)-1:0]       tid,
  input  logic [(dest_width > 0 ? dest_width : 1)-1:0]   tdest,
  input  logic [(user_width > 0 ? user_width : 1)-1:0]   tuser,
  output logic [6:0]                                     violation,
  output logic [6:0]                                     first_violation,
  output logic [count_width-1:0]                         xfer_count,
  output logic [count_width-1:0]                         byte_count,
  output logic [count_width-1:0]                         packet_count,
  output logic [count_width-1:0]                         stall_count,
  output logic [(2**dest_width)-1:0]                     in_packet
);

  localparam int unsigned IdW     = id_width > 0 ? id_width : 1;
  localparam int unsigned DestW   = dest_width > 0 ? dest_width : 1;
  localparam int unsigned UserW   = user_width > 0 ? user_width : 1;
  localparam int unsigned NumDest = 2 ** dest_width;
  localparam int unsigned PayW    = 8 * byte_width + 2 * byte_width + 1 + IdW + DestW + UserW;
  localparam int unsigned PcW     = $clog2(byte_width + 1);
  localparam int unsigned LenW    = $clog2(max_packet_len + 2);
  localparam int unsigned RunW    = $clog2(stall_limit + 2);
  localparam logic [LenW-1:0] LenMax = LenW'(max_packet_len + 1);
  localparam logic [RunW-1:0] RunMax = RunW'(stall_limit + 1);

  logic                          hs, stall;
  logic [IdW-1:0]                tid_m;
  logic [DestW-1:0]              d;
  logic [UserW-1:0]              user_m;
  logic [PayW-1:0]               payload;
  logic [PcW-1:0]                keep_cnt;
  logic [6:0]                    new_viol;

  logic                          post_rst_q;
  logic                          prev_stall_q, prev_stall_d;
  logic [PayW-1:0]               prev_payload_q, prev_payload_d;
  logic [RunW-1:0]               run_q, run_d;
  logic [NumDest-1:0]            in_packet_q, in_packet_d;
  logic [NumDest-1:0][LenW-1:0]  len_q, len_d;
  logic [NumDest-1:0][IdW-1:0]   tid_q, tid_d;
  logic [6:0]                    violation_q, violation_d;
  logic [6:0]                    first_q, first_d;
  logic [count_width-1:0]        xfer_q, xfer_d, byte_q, byte_d;
  logic [count_width-1:0]        pkt_q, pkt_d, stall_q, stall_d;

  assign hs    = tvalid && tready;
  assign stall = tvalid && !tready;

  // Absent sidebands read as zero so they never trigger a check.
  always_comb begin
    tid_m   = (id_width > 0) ? tid : '0;
    d       = (dest_width > 0) ? tdest : '0;
    user_m  = (user_width > 0) ? tuser : '0;
    payload = {tdata, tstrb, tkeep, tlast, tid_m, d, user_m};
  end

  axi_stream_popcount #(
    .width     (byte_width),
    .out_width (PcW)
  ) u_popcount (
    .bits_i  (tkeep),
    .count_o (keep_cnt)
  );

  // Detect this cycle's violations; only the reset check runs in the cycle after reset.
  always_comb begin
    new_viol = '0;
    if (post_rst_q) begin
      new_viol[VIOL_VALID_AFTER_RESET] = tvalid;
    end else begin
      new_viol[VIOL_VALID_DROP]      = prev_stall_q && !tvalid;
      new_viol[VIOL_PAYLOAD_CHANGE]  = prev_stall_q && (payload != prev_payload_q);
      new_viol[VIOL_STRB_NOT_KEEP]   = tvalid && ((tstrb & ~tkeep) != '0);
      new_viol[VIOL_PACKET_TOO_LONG] = (max_packet_len != 0) && hs &&
                                       (int'(len_q[d]) + 1 > int'(max_packet_len));
      new_viol[VIOL_INTERLEAVE]      = !allow_interleave && hs && in_packet_q[d] &&
                                       (tid_m != tid_q[d]);
      // run_q == limit means this stall makes the run exceed it; saturation stops re-firing.
      new_viol[VIOL_STALL_TIMEOUT]   = (stall_limit != 0) && stall &&
                                       (int'(run_q) == int'(stall_limit));
    end
  end

  // Next state: clear zeroes flags/counters first, then this cycle's events apply.
  always_comb begin
    logic [count_width-1:0] xb, bb, pb, sb;
    xb = clear ? '0 : xfer_q;
    bb = clear ? '0 : byte_q;
    pb = clear ? '0 : pkt_q;
    sb = clear ? '0 : stall_q;
    xfer_d  = count_width'(sat_inc(64'(xb), 64'(hs), count_width));
    byte_d  = count_width'(sat_inc(64'(bb), hs ? 64'(keep_cnt) : 64'd0, count_width));
    pkt_d   = count_width'(sat_inc(64'(pb), 64'(hs && tlast), count_width));
    stall_d = count_width'(sat_inc(64'(sb), 64'(stall), count_width));

    violation_d = (clear ? 7'd0 : violation_q) | new_viol;
    first_d     = clear ? 7'd0 : first_q;
    if (first_d == 7'd0) begin
      first_d = new_viol;
    end

    prev_stall_d   = stall;
    prev_payload_d = payload;
    run_d          = stall ? ((run_q == RunMax) ? run_q : run_q + 1'b1) : '0;

    in_packet_d = in_packet_q;
    len_d       = len_q;
    tid_d       = tid_q;
    if (hs) begin
      if (tlast) begin
        in_packet_d[d] = 1'b0;
        len_d[d]       = '0;
      end else begin
        if (!in_packet_q[d]) begin
          tid_d[d] = tid_m;
        end
        in_packet_d[d] = 1'b1;
        if (len_q[d] != LenMax) begin
          len_d[d] = len_q[d] + 1'b1;
        end
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      post_rst_q     <= 1'b1;
      prev_stall_q   <= 1'b0;
      prev_payload_q <= '0;
      run_q          <= '0;
      in_packet_q    <= '0;
      len_q          <= '0;
      tid_q          <= '0;
      violation_q    <= '0;
      first_q        <= '0;
      xfer_q         <= '0;
      byte_q         <= '0;
      pkt_q          <= '0;
      stall_q        <= '0;
    end else begin
      post_rst_q     <= 1'b0;
      prev_stall_q   <= prev_stall_d;
      prev_payload_q <= prev_payload_d;
      run_q          <= run_d;
      in_packet_q    <= in_packet_d;
      len_q          <= len_d;
      tid_q          <= tid_d;
      violation_q    <= violation_d;
      first_q        <= first_d;
      xfer_q         <= xfer_d;
      byte_q         <= byte_d;
      pkt_q          <= pkt_d;
      stall_q        <= stall_d;
    end
  end

  assign violation       = violation_q;
  assign first_violation = first_q;
  assign xfer_count      = xfer_q;
  assign byte_count      = byte_q;
  assign packet_count    = pkt_q;
  assign stall_count     = stall_q;
  assign in_packet       = in_packet_q;

endmodule

// File: tb/tb_axi_stream_checker.sv
// Directed bench for axi_stream_checker with hand-computed expectations.
module tb_axi_stream_checker;

  logic        clk = 1'b0;
  logic        resetn, clear, tvalid, tready, tlast;
  logic [31:0] tdata;
  logic [3:0]  tstrb, tkeep;
  logic [1:0]  tid;
  logic [0:0]  tdest, tuser;
  logic [6:0]  violation, first_violation;
  logic [7:0]  xfer_count, byte_count, packet_count, stall_count;
  logic [1:0]  in_packet;

  int n_tests = 0;
  int n_fail  = 0;

  axi_stream_checker #(
    .byte_width       (4),
    .id_width         (2),
    .dest_width       (1),
    .user_width       (1),
    .count_width      (8),
    .max_packet_len   (4),
    .stall_limit      (3),
    .allow_interleave (1'b0)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .clear           (clear),
    .tvalid          (tvalid),
    .tready          (tready),
    .tlast           (tlast),
    .tdata           (tdata),
    .tstrb           (tstrb),
    .tkeep           (tkeep),
    .tid             (tid),
    .tdest           (tdest),
    .tuser           (tuser),
    .violation       (violation),
    .first_violation (first_violation),
    .xfer_count      (xfer_count),
    .byte_count      (byte_count),
    .packet_count    (packet_count),
    .stall_count     (stall_count),
    .in_packet       (in_packet)
  );

  always #5 clk = ~clk;

  // One clock; outputs then reflect the cycle just applied.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int x, input int b, input int p, input int s);
    chk({tag, "_xfer"}, 32'(xfer_count), x);
    chk({tag, "_bytes"}, 32'(byte_count), b);
    chk({tag, "_pkts"}, 32'(packet_count), p);
    chk({tag, "_stall"}, 32'(stall_count), s);
  endtask

  task automatic beat(input logic last, input logic [3:0] keep, input logic [1:0] id,
                      input logic dst);
    tvalid = 1'b1; tready = 1'b1; tlast = last; tkeep = keep; tstrb = keep;
    tid = id; tdest = dst;
    cyc();
  endtask

  initial begin
    resetn = 1'b0; clear = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
    tdata = 32'h0; tstrb = 4'h0; tkeep = 4'h0; tid = 2'd0; tdest = 1'b0; tuser = 1'b0;
    cyc(); cyc();
    chk("rst_viol", 32'(violation), 0);
    chk("rst_first", 32'(first_violation), 0);
    chk_cnt("rst", 0, 0, 0, 0);
    chk("rst_inpkt", 32'(in_packet), 0);
    resetn = 1'b1;
    cyc();
    chk("postrst_viol", 32'(violation), 0);

    // 3-beat packet
    beat(1'b0, 4'hF, 2'd1, 1'b0);
    chk("pkt_open", 32'(in_packet), 1);
    beat(1'b0, 4'hF, 2'd1, 1'b0);
    beat(1'b1, 4'h3, 2'd1, 1'b0);
    chk_cnt("pkt3", 3, 10, 1, 0);
    chk("pkt3_inpkt", 32'(in_packet), 0);
    chk("pkt3_viol", 32'(violation), 0);
    tvalid = 1'b0; cyc();
    chk("idle_viol", 32'(violation), 0);

    // Payload change during a stall
    tvalid = 1'b1; tready = 1'b0; tlast = 1'b1; tkeep = 4'hF; tstrb = 4'hF; tdata = 32'hA;
    cyc();
    chk("stall1_viol", 32'(violation), 0);
    tdata = 32'hB; cyc();
    chk("chg_viol", 32'(violation), 7'b0000010);
    chk("chg_first", 32'(first_violation), 7'b0000010);
    chk("chg_stall", 32'(stall_count), 2);
    tready = 1'b1; cyc();
    chk_cnt("chg_hs", 4, 14, 2, 2);
    tvalid = 1'b0; cyc();

    // Clear coincident with a handshake
    clear = 1'b1; beat(1'b1, 4'h3, 2'd1, 1'b0); clear = 1'b0;
    chk("clr_viol", 32'(violation), 0);
    chk("clr_first", 32'(first_violation), 0);
    chk_cnt("clr", 1, 2, 1, 0);
    tvalid = 1'b0; cyc();

    // Packet too long (limit 4)
    for (int i = 0; i < 4; i++) beat(1'b0, 4'hF, 2'd1, 1'b0);
    chk("len4_viol", 32'(violation), 0);
    beat(1'b0, 4'hF, 2'd1, 1'b0);
    chk("len5_viol", 32'(violation), 7'b0010000);
    chk("len5_first", 32'(first_violation), 7'b0010000);
    chk("len5_xfer", 32'(xfer_count), 6);
    beat(1'b1, 4'hF, 2'd1, 1'b0);
    chk("len_close", 32'(in_packet), 0);
    tvalid = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;

    // Interleave on the same TDEST versus another TDEST
    beat(1'b0, 4'hF, 2'd1, 1'b0);
    beat(1'b0, 4'hF, 2'd2, 1'b1);
    chk("il_other_viol", 32'(violation), 0);
    chk("il_inpkt", 32'(in_packet), 2'b11);
    beat(1'b0, 4'hF, 2'd2, 1'b0);
    chk("il_viol", 32'(violation), 7'b0100000);
    beat(1'b1, 4'hF, 2'd1, 1'b0);
    beat(1'b1, 4'hF, 2'd2, 1'b1);
    chk("il_close", 32'(in_packet), 0);
    chk("il_hold", 32'(violation), 7'b0100000);
    tvalid = 1'b0; clear = 1'b1; cyc(); clear = 1'b0;

    // Stall timeout (limit 3)
    tvalid = 1'b1; tready = 1'b0; tlast = 1'b1;
    cyc(); cyc(); cyc();
    chk("st3_viol", 32'(violation), 0);
    cyc();
    chk("st4_viol", 32'(violation), 7'b1000000);
    cyc();
    chk("st5_stall", 32'(stall_count), 5);
    chk("st5_first", 32'(first_violation), 7'b1000000);
    tready = 1'b1; cyc();
    tvalid = 1'b0; cyc();
    clear = 1'b1; cyc(); clear = 1'b0;

    // tvalid dropped without handshake
    tvalid = 1'b1; tready = 1'b0; cyc();
    tvalid = 1'b0; cyc();
    chk("drop_viol", 32'(violation), 7'b0000001);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("drop_clr", 32'(violation), 0);

    // tstrb outside tkeep
    tvalid = 1'b1; tready = 1'b1; tstrb = 4'hF; tkeep = 4'h3; cyc();
    chk("strb_viol", 32'(violation), 7'b0000100);
    tvalid = 1'b0; tstrb = 4'h3; cyc();

    // Reset mid-packet, then tvalid in the first cycle after reset
    beat(1'b0, 4'hF, 2'd1, 1'b0);
    chk("mid_open", 32'(in_packet), 1);
    tvalid = 1'b0; resetn = 1'b0; cyc();
    chk("mid_rst_inpkt", 32'(in_packet), 0);
    chk("mid_rst_viol", 32'(violation), 0);
    chk_cnt("mid_rst", 0, 0, 0, 0);
    resetn = 1'b1; tvalid = 1'b1; tready = 1'b1; tlast = 1'b1; tstrb = 4'hF; tkeep = 4'h3;
    cyc();
    chk("var_viol", 32'(violation), 7'b0001000);
    chk("var_first", 32'(first_violation), 7'b0001000);
    chk_cnt("var", 1, 2, 1, 0);
    tvalid = 1'b0; tstrb = 4'h3; cyc();
    chk("var_hold", 32'(violation), 7'b0001000);

    // Saturation of 8-bit counters
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < 70; i++) beat(1'b1, 4'hF, 2'd0, 1'b0);
    chk_cnt("sat70", 70, 255, 70, 0);
    for (int i = 0; i < 200; i++) beat(1'b1, 4'hF, 2'd0, 1'b0);
    chk_cnt("sat270", 255, 255, 255, 0);
    chk("sat_viol", 32'(violation), 0);
    tvalid = 1'b0; cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
